// File: rtl/spine_router_param_if.sv
// -----------------------------------------------------------------------------
// spine_router_param_if
//   Flit-level handshake bundle between a spine router and its neighbours.
//   All fields are flat vectors. Port p occupies [p*DWIDTH +: DWIDTH] in the
//   data vectors and bit p in the single-bit vectors.
//
//   in_data   : flits offered to the router, one per port
//   in_valid  : per-port flit valid
//   in_ready  : per-port accept (router input FIFO not full)
//   out_data  : registered flit leaving the router, one per port
//   out_valid : per-port output valid
//   out_ready : per-port downstream accept
//
//   master : the environment side (drives inputs and out_ready)
//   slave  : the router side
// -----------------------------------------------------------------------------
interface spine_router_param_if #(
  parameter int NUM_PORTS = 11,
  parameter int DWIDTH    = 16
);
  logic [NUM_PORTS*DWIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [NUM_PORTS*DWIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]        out_valid;
  logic [NUM_PORTS-1:0]        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/spine_router_param.sv
// -----------------------------------------------------------------------------
// spine_router_param
//   Group-level spine router. NUM_LEAF leaf ports followed by NUM_GROUPS-1
//   inter-group ports (port NUM_LEAF+k is group port k). Every input has a
//   FIFO; the head flit is routed by its destination group/leaf fields; every
//   output has a round-robin arbiter feeding a ready/valid output register.
//   Heads with an unroutable address are popped immediately and counted.
//
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low; clears all state
//   bus        : flit handshake bundle (slave side)
//   drop_count : saturating count of dropped flits
//   drop_pulse : high for one cycle after any cycle with a drop
// -----------------------------------------------------------------------------
module spine_router_param #(
  parameter int GROUP_ID   = 7,
  parameter int NUM_GROUPS = 8,
  parameter int NUM_LEAF   = 4,
  parameter int DWIDTH     = 16,
  parameter int GID_W      = 4,
  parameter int LID_W      = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  spine_router_param_if.slave bus,
  output logic [15:0]         drop_count,
  output logic                drop_pulse
);

  localparam int NUM_PORTS = NUM_LEAF + NUM_GROUPS - 1;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int PIDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SUM_W     = PIDX_W + 1;

  // Input FIFO storage and bookkeeping
  logic [DWIDTH-1:0]    mem    [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr [NUM_PORTS];
  logic [PTR_W-1:0]     rd_ptr [NUM_PORTS];
  logic [CNT_W-1:0]     count  [NUM_PORTS];

  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] head_valid;
  logic [NUM_PORTS-1:0] route_ok;
  logic [NUM_PORTS-1:0] drop;
  logic [NUM_PORTS-1:0] granted_in;
  logic [NUM_PORTS-1:0] any_req;
  logic [NUM_PORTS-1:0] load_en;
  logic [DWIDTH-1:0]    head_data [NUM_PORTS];
  logic [PIDX_W-1:0]    target    [NUM_PORTS];

  // req[o][i]: input i's head wants output o
  logic [NUM_PORTS-1:0] req    [NUM_PORTS];
  logic [PIDX_W-1:0]    rr_ptr [NUM_PORTS];
  logic [PIDX_W-1:0]    win    [NUM_PORTS];

  logic [DWIDTH-1:0]    out_data_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_valid_q;
  logic [16:0]          drop_sum;

  // ---------------------------------------------------------------------------
  // Per-input: accept, head view and route decode
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [GID_W-1:0]  dgrp;
    logic [LID_W-1:0]  dleaf;
    logic              ok;
    logic [PIDX_W-1:0] tgt;

    assign bus.in_ready[p] = (count[p] != CNT_W'(FIFO_DEPTH));
    assign push[p]         = bus.in_valid[p] & bus.in_ready[p];
    assign head_valid[p]   = (count[p] != '0);
    assign head_data[p]    = mem[p][rd_ptr[p]];
    assign dgrp            = head_data[p][DWIDTH-1 -: GID_W];
    assign dleaf           = head_data[p][DWIDTH-1-GID_W -: LID_W];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
      ok  = 1'b0;
      tgt = '0;
      if (int'(dgrp) == GROUP_ID) begin
        if (int'(dleaf) < NUM_LEAF) begin
          ok  = 1'b1;
          tgt = PIDX_W'(dleaf);
        end
      end else if (int'(dgrp) < NUM_GROUPS) begin
        // Group ports skip our own group number.
        ok  = 1'b1;
        tgt = PIDX_W'(NUM_LEAF + int'(dgrp) - ((int'(dgrp) > GROUP_ID) ? 1 : 0));
      end
    end

    assign route_ok[p] = ok;
    assign target[p]   = tgt;
    // Unroutable heads leave without arbitration; routable ones only on grant.
    assign drop[p]     = head_valid[p] & ~ok;
    assign pop[p]      = drop[p] | granted_in[p];

    assign bus.out_data[p*DWIDTH +: DWIDTH] = out_data_q[p];
  end

  assign bus.out_valid = out_valid_q;
  assign load_en       = ~out_valid_q | bus.out_ready;

  // ---------------------------------------------------------------------------
  // Request matrix and round-robin arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = head_valid[i] & route_ok[i] & (int'(target[i]) == o);
      end
    end
  end

  always_comb begin : arb
    logic [SUM_W-1:0]  sum;
    logic [PIDX_W-1:0] idx;
    sum        = '0;
    idx        = '0;
    granted_in = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      any_req[o] = 1'b0;
      win[o]     = rr_ptr[o];
      // Scan from the pointer, wrapping at NUM_PORTS; first requester wins.
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum = {1'b0, rr_ptr[o]} + SUM_W'(k);
        if (sum >= SUM_W'(NUM_PORTS)) sum = sum - SUM_W'(NUM_PORTS);
        idx = sum[PIDX_W-1:0];
        if (!any_req[o] && req[o][idx]) begin
          any_req[o] = 1'b1;
          win[o]     = idx;
        end
      end
      // Each input targets one output only, so at most one grant per input.
      if (load_en[o] && any_req[o]) granted_in[win[o]] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking is reserved for combinational temps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p] <= count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= bus.in_data[p*DWIDTH +: DWIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers and RR pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= '0;
        rr_ptr[o]     <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (load_en[o] && any_req[o]) begin
          out_data_q[o]  <= head_data[win[o]];
          out_valid_q[o] <= 1'b1;
          rr_ptr[o]      <= (win[o] == PIDX_W'(NUM_PORTS - 1)) ? '0 : win[o] + 1'b1;
        end else if (bus.out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int p = 0; p < NUM_PORTS; p++) begin
      drop_sum = drop_sum + 17'(drop[p]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      drop_pulse <= |drop;
    end
  end

endmodule

// File: tb/tb_spine_router_param.sv
// -----------------------------------------------------------------------------
// tb_spine_router_param
//   Directed bench for spine_router_param. Main instance uses default
//   parameters (11 ports); a second instance with NUM_LEAF=3 (10 ports)
//   exercises the out-of-range leaf drop. Inputs are driven and outputs
//   sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_spine_router_param;

  localparam int DW  = 16;
  localparam int NP  = 11;
  localparam int NP3 = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] drop_count;
  logic        drop_pulse;
  logic [15:0] drop_count3;
  logic        drop_pulse3;

  int n_checks = 0;
  int n_errors = 0;

  int grp_v [3] = '{3, 0, 5};
  int tgt_v [3] = '{7, 4, 9};
  int src_v [3] = '{0, 1, 5};

  spine_router_param_if #(.NUM_PORTS(NP),  .DWIDTH(DW)) bus_if ();
  spine_router_param_if #(.NUM_PORTS(NP3), .DWIDTH(DW)) bus3 ();

  spine_router_param dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .drop_count (drop_count),
    .drop_pulse (drop_pulse)
  );

  spine_router_param #(.NUM_LEAF(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus3),
    .drop_count (drop_count3),
    .drop_pulse (drop_pulse3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input int g, input int l, input int pl);
    return {g[3:0], l[1:0], pl[9:0]};
  endfunction

  task automatic drive(input int p, input logic [15:0] d, input logic v);
    bus_if.in_data[p*DW +: DW] = d;
    bus_if.in_valid[p]         = v;
  endtask

  task automatic drive3(input int p, input logic [15:0] d, input logic v);
    bus3.in_data[p*DW +: DW] = d;
    bus3.in_valid[p]         = v;
  endtask

  function automatic logic [15:0] od(input int p);
    return bus_if.out_data[p*DW +: DW];
  endfunction

  // Wait (bounded) for output p, then require it alone valid carrying d.
  task automatic expect_out(input string tag, input int p, input logic [15:0] d);
    int n;
    n = 0;
    while (!bus_if.out_valid[p] && n < 10) begin
      step();
      n++;
    end
    check({tag, "_v"}, 32'(bus_if.out_valid), 32'(1) << p);
    check({tag, "_d"}, 32'(od(p)), 32'(d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    logic [15:0] exp_q [12];
    logic        acc;
    int          n, first_c, last_c, n_acc, seen;

    // ---------------- reset -------------------------------------------------
    reset            = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_valid  = '1;
    bus_if.out_ready = '1;
    bus3.in_data     = '0;
    bus3.in_valid    = '0;
    bus3.out_ready   = '1;
    step();
    step();
    check("rst_in_ready",  32'(bus_if.in_ready),  'h7FF);
    check("rst_out_valid", 32'(bus_if.out_valid), 0);
    check("rst_out_data4", 32'(od(4)),            0);
    check("rst_drop_cnt",  32'(drop_count),       0);
    check("rst_drop_pls",  32'(drop_pulse),       0);
    bus_if.in_valid = '0;
    reset = 1'b1;

    // ---------------- latency: leaf0 -> leaf2 ------------------------------
    drive(0, mk(7, 2, 'hAB), 1'b1);
    step();
    drive(0, '0, 1'b0);
    check("lat_t1_v", 32'(bus_if.out_valid), 0);
    step();
    check("lat_t2_v", 32'(bus_if.out_valid), 'h004);
    check("lat_t2_d", 32'(od(2)),            'h78AB);
    step();
    check("lat_drain", 32'(bus_if.out_valid), 0);

    // ---------------- group routing from leaf1 ------------------------------
    for (int i = 0; i < 3; i++) begin
      f = mk(grp_v[i], i + 1, 'h155 + i * 'h51);
      drive(1, f, 1'b1);
      step();
      drive(1, '0, 1'b0);
      expect_out($sformatf("grp%0d", grp_v[i]), tgt_v[i], f);
      step();
    end

    // ---------------- contention on leaf3 -----------------------------------
    for (int k = 0; k < 12; k++) exp_q[k] = mk(7, 3, src_v[k % 3] * 16 + k / 3);
    n = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 30; c++) begin
      for (int j = 0; j < 3; j++) drive(src_v[j], mk(7, 3, src_v[j] * 16 + c), c < 4);
      step();
      if (bus_if.out_valid[3]) begin
        if (n < 12) check($sformatf("rr%0d", n), 32'(od(3)), 32'(exp_q[n]));
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
    end
    check("rr_count", n, 12);
    check("rr_b2b",   last_c - first_c, 11);

    // ---------------- backpressure on leaf2 ---------------------------------
    bus_if.out_ready[2] = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 14; c++) begin
      drive(0, mk(7, 2, 'h100 + n_acc), 1'b1);
      acc = bus_if.in_ready[0];
      step();
      if (acc) n_acc++;
    end
    drive(0, '0, 1'b0);
    check("bp_accepts",  n_acc, 9);
    check("bp_in_ready", 32'(bus_if.in_ready[0]),  0);
    check("bp_hold_v",   32'(bus_if.out_valid[2]), 1);
    check("bp_hold_d",   32'(od(2)),               32'(mk(7, 2, 'h100)));
    bus_if.out_ready[2] = 1'b1;
    n = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_if.out_valid[2]) begin
        if (n < 9) check($sformatf("bp_out%0d", n), 32'(od(2)), 32'(mk(7, 2, 'h100 + n)));
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
      step();
    end
    check("bp_count",       n, 9);
    check("bp_b2b",         last_c - first_c, 8);
    check("bp_in_ready_up", 32'(bus_if.in_ready[0]), 1);

    // ---------------- drops: bad group on main instance ---------------------
    drive(2, mk(9, 0, 1), 1'b1);
    drive(3, mk(15, 3, 2), 1'b1);
    step();
    drive(2, '0, 1'b0);
    drive(3, '0, 1'b0);
    check("drop_pre_cnt", 32'(drop_count), 0);
    check("drop_pre_pls", 32'(drop_pulse), 0);
    step();
    check("drop_cnt",   32'(drop_count),       2);
    check("drop_pls",   32'(drop_pulse),       1);
    check("drop_noout", 32'(bus_if.out_valid), 0);
    step();
    check("drop_pls_off", 32'(drop_pulse), 0);
    check("drop_cnt_hld", 32'(drop_count), 2);

    // ---------------- drops: bad group + bad leaf on NUM_LEAF=3 -------------
    drive3(0, mk(9, 0, 5), 1'b1);
    drive3(1, mk(7, 3, 6), 1'b1);
    step();
    drive3(0, '0, 1'b0);
    drive3(1, '0, 1'b0);
    check("d3_pre_cnt", 32'(drop_count3), 0);
    step();
    check("d3_cnt",   32'(drop_count3),    2);
    check("d3_pls",   32'(drop_pulse3),    1);
    check("d3_noout", 32'(bus3.out_valid), 0);
    step();
    check("d3_pls_off", 32'(drop_pulse3), 0);

    // ---------------- saturation: 11 drops per cycle ------------------------
    for (int p = 0; p < NP; p++) drive(p, 16'hF000, 1'b1);
    for (int c = 0; c < 5957; c++) step();
    for (int p = 0; p < NP; p++) drive(p, '0, 1'b0);
    step();
    step();
    check("sat_below", 32'(drop_count), 65529);
    for (int p = 0; p < NP; p++) drive(p, 16'hF000, 1'b1);
    step();
    for (int p = 0; p < NP; p++) drive(p, '0, 1'b0);
    step();
    check("sat_clip", 32'(drop_count), 'hFFFF);
    check("sat_pls",  32'(drop_pulse), 1);
    for (int p = 0; p < NP; p++) drive(p, 16'hF000, 1'b1);
    step();
    for (int p = 0; p < NP; p++) drive(p, '0, 1'b0);
    step();
    step();
    check("sat_hold", 32'(drop_count), 'hFFFF);

    // ---------------- mid-operation asynchronous reset ----------------------
    bus_if.out_ready[4] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(0, mk(0, 1, 'h40 + c), 1'b1);
      step();
    end
    drive(0, '0, 1'b0);
    check("mid_pre_v4", 32'(bus_if.out_valid[4]), 1);
    check("mid_pre_rdy", 32'(bus_if.in_ready[0]), 1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_out_valid", 32'(bus_if.out_valid), 0);
    check("mid_out_data4", 32'(od(4)),            0);
    check("mid_in_ready",  32'(bus_if.in_ready),  'h7FF);
    check("mid_drop_cnt",  32'(drop_count),       0);
    #2;
    reset = 1'b1;
    bus_if.out_ready = '1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (|bus_if.out_valid) seen++;
    end
    check("mid_no_stale", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
